weight_bank_receiver: RTL and testbench

Receiving end of the ROM load path: captures the 32-bit words written by the ROM controller (address/writeData/data strobe) into a 4-entry register bank and tracks which slots are loaded. When the controller's start_network_controller pulse arrives with all slots filled, it streams the words in address order to the network datapath over a valid/ready handshake, then pulses done. Sits between the ROM controller and the neuron/MAC stage.

---
 rtl/weight_bank_receiver.sv | 159 +++++++++++++++
 tb/tb_weight_bank_receiver.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_bank_receiver.sv
// Purpose : capture ROM-controller words into a NUM_WORDS register bank; on start
//           with every slot loaded, stream them in address order, then pulse done.
// Latency : start sampled at edge N -> word 0 valid from edge N+1; one word/cycle.
// Backpressure: word_out/word_index held while word_ready=0; writes while busy
//           are dropped and flagged with write_dropped.
//
// Ports:
//   clk, reset (async, active-low)
//   data_in/address/writeData  : slot write port from the ROM controller
//   start_network              : single-cycle start pulse
//   word_ready                 : downstream accept for word_out
//   word_out/word_index/word_valid : streamed word, its slot, valid flag
//   busy, done, load_error, write_dropped : status / one-cycle event pulses
//
// Optional feature: define WEIGHT_BANK_REPLAY_EN to keep the loaded mask after
// a stream so a later start replays the same words without a reload.
module weight_bank_receiver #(
    parameter int NUM_WORDS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  writeData,
    input  logic                  start_network,
    input  logic                  word_ready,
    output logic [DATA_WIDTH-1:0] word_out,
    output logic                  word_valid,
    output logic [ADDR_WIDTH-1:0] word_index,
    output logic                  busy,
    output logic                  done,
    output logic                  load_error,
    output logic                  write_dropped
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  bank_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0]  bank_d [NUM_WORDS];
    logic [NUM_WORDS-1:0]   loaded_q, loaded_d;
    logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  word_out_q, word_out_d;
    logic                   load_error_q, load_error_d;
    logic                   write_dropped_q, write_dropped_d;

    logic                   idle_wr;
    logic [NUM_WORDS-1:0]   mask_next;
    logic                   bank_full;
    logic                   start_ok;
    logic                   handshake;
    logic                   last_word;
    logic [ADDR_WIDTH-1:0]  idx_inc;

    // A write in the same cycle as start counts toward the full check.
    assign idle_wr   = (state_q == ST_IDLE) && writeData;
    assign mask_next = loaded_q | (idle_wr ? (NUM_WORDS'(1) << address) : '0);
    assign bank_full = &mask_next;
    assign start_ok  = (state_q == ST_IDLE) && start_network && bank_full;
    assign handshake = (state_q == ST_STREAM) && word_ready;
    assign last_word = (idx_q == ADDR_WIDTH'(NUM_WORDS - 1));
    assign idx_inc   = idx_q + 1'b1;

    // State register and datapath flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            loaded_q        <= '0;
            idx_q           <= '0;
            word_out_q      <= '0;
            load_error_q    <= 1'b0;
            write_dropped_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            loaded_q        <= loaded_d;
            idx_q           <= idx_d;
            word_out_q      <= word_out_d;
            load_error_q    <= load_error_d;
            write_dropped_q <= write_dropped_d;
            for (int i = 0; i < NUM_WORDS; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_STREAM;
            ST_STREAM: if (handshake && last_word) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            bank_d[i] = bank_q[i];
        end
        loaded_d        = loaded_q;
        idx_d           = idx_q;
        word_out_d      = word_out_q;
        load_error_d    = (state_q == ST_IDLE) && start_network && !bank_full;
        write_dropped_d = writeData && (state_q != ST_IDLE);

        if (idle_wr) begin
            bank_d[address] = data_in;
        end

        case (state_q)
            ST_IDLE: begin
                // A failed start keeps the partial mask so loading can resume.
                loaded_d = mask_next;
                if (start_ok) begin
                    idx_d      = '0;
                    // bank_d so a same-cycle write to slot 0 is streamed.
                    word_out_d = bank_d[0];
                end
            end
            ST_STREAM: begin
                if (handshake && !last_word) begin
                    idx_d      = idx_inc;
                    word_out_d = bank_q[idx_inc];
                end
            end
            ST_DONE: begin
`ifdef WEIGHT_BANK_REPLAY_EN
                loaded_d = loaded_q;
`else
                loaded_d = '0;
`endif
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        word_valid    = (state_q == ST_STREAM);
        busy          = (state_q == ST_STREAM) || (state_q == ST_DONE);
        done          = (state_q == ST_DONE);
        word_out      = word_out_q;
        word_index    = idx_q;
        load_error    = load_error_q;
        write_dropped = write_dropped_q;
    end

endmodule

// File: tb/tb_weight_bank_receiver.sv
module tb_weight_bank_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic [1:0]  address;
    logic        writeData;
    logic        start_network;
    logic        word_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic [1:0]  word_index;
    logic        busy;
    logic        done;
    logic        load_error;
    logic        write_dropped;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: slot contents and which slots hold a fresh load.
    logic [31:0] mbank [4];
    logic [3:0]  mmask;

    always #5 clk = ~clk;

    weight_bank_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .address      (address),
        .writeData    (writeData),
        .start_network(start_network),
        .word_ready   (word_ready),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_index   (word_index),
        .busy         (busy),
        .done         (done),
        .load_error   (load_error),
        .write_dropped(write_dropped)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change at negedge; outputs are checked at the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        mmask = 4'b0;
        for (int i = 0; i < 4; i++) mbank[i] = 32'h0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        writeData = 1'b1;
        address   = a;
        data_in   = d;
        tick();
        writeData = 1'b0;
        mbank[a]  = d;
        mmask[a]  = 1'b1;
        check("idle_write_not_dropped", {31'b0, write_dropped}, 32'd0);
    endtask

    // Pulses start (optionally with a same-cycle write); returns whether a stream began.
    task automatic start_and_check(input bit wr, input logic [1:0] a, input logic [31:0] d,
                                   output bit started);
        writeData     = wr;
        address       = a;
        data_in       = d;
        start_network = 1'b1;
        if (wr) begin
            mbank[a] = d;
            mmask[a] = 1'b1;
        end
        started = (mmask == 4'hF);
        tick();
        writeData     = 1'b0;
        start_network = 1'b0;
        if (started) begin
            check("start_valid", {31'b0, word_valid}, 32'd1);
            check("start_index", {30'b0, word_index}, 32'd0);
            check("start_word0", word_out, mbank[0]);
            check("start_busy", {31'b0, busy}, 32'd1);
            check("start_no_err", {31'b0, load_error}, 32'd0);
        end else begin
            check("err_pulse", {31'b0, load_error}, 32'd1);
            check("err_no_valid", {31'b0, word_valid}, 32'd0);
            check("err_not_busy", {31'b0, busy}, 32'd0);
            tick();
            check("err_one_cycle", {31'b0, load_error}, 32'd0);
            check("err_still_idle", {31'b0, word_valid}, 32'd0);
        end
    endtask

    // mode 0: ready always high, 1: random, 2: fixed 1,0,0,1,1,0,1 pattern.
    // With disturb set, a write to drop_addr and a stray start are issued mid-stream.
    task automatic stream(input int mode, input bit disturb, input logic [1:0] drop_addr);
        int k   = 0;
        int cyc = 0;
        bit r;
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        while (k < 4 && cyc < 200) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : pat[cyc % 7];
            word_ready = r;
            if (disturb && cyc == 1) begin
                writeData     = 1'b1;
                address       = drop_addr;
                data_in       = 32'hFFFF_FFFF;
                start_network = 1'b1;
            end else begin
                writeData     = 1'b0;
                start_network = 1'b0;
            end
            check("stream_valid", {31'b0, word_valid}, 32'd1);
            check("stream_index", {30'b0, word_index}, k);
            check("stream_word", word_out, mbank[k]);
            if (r) k++;
            tick();
            cyc++;
            if (disturb && cyc == 2) begin
                check("write_dropped", {31'b0, write_dropped}, 32'd1);
                check("stray_start_no_err", {31'b0, load_error}, 32'd0);
            end
            if (disturb && cyc == 3) begin
                check("write_dropped_one_cycle", {31'b0, write_dropped}, 32'd0);
            end
        end
        writeData     = 1'b0;
        start_network = 1'b0;
        word_ready    = 1'b0;
        check("stream_handshakes", k, 32'd4);
        check("done_pulse", {31'b0, done}, 32'd1);
        check("done_busy", {31'b0, busy}, 32'd1);
        check("done_no_valid", {31'b0, word_valid}, 32'd0);
        tick();
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("idle_not_busy", {31'b0, busy}, 32'd0);
`ifndef WEIGHT_BANK_REPLAY_EN
        mmask = 4'b0;
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_word_out"}, word_out, 32'd0);
        check({tag, "_valid"}, {31'b0, word_valid}, 32'd0);
        check({tag, "_index"}, {30'b0, word_index}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_load_error"}, {31'b0, load_error}, 32'd0);
        check({tag, "_write_dropped"}, {31'b0, write_dropped}, 32'd0);
    endtask

    initial begin
        bit started;
        reset         = 1'b0;
        data_in       = '0;
        address       = '0;
        writeData     = 1'b0;
        start_network = 1'b0;
        word_ready    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Basic load and stream.
        do_write(2'd0, 32'hA000_0000);
        do_write(2'd1, 32'h0000_00A1);
        do_write(2'd2, 32'h0000_00A2);
        do_write(2'd3, 32'h0000_00A3);
        start_and_check(1'b0, 2'd0, 32'h0, started);
        if (started) stream(0, 1'b0, 2'd0);

        // Incomplete bank rejected, then completed.
        model_reset();
        do_write(2'd0, 32'h1111_0000);
        do_write(2'd1, 32'h1111_0001);
        do_write(2'd2, 32'h1111_0002);
        start_and_check(1'b0, 2'd0, 32'h0, started);
        check("partial_rejected", {31'b0, started}, 32'd0);
        do_write(2'd3, 32'h1111_0003);
        start_and_check(1'b0, 2'd0, 32'h0, started);
        if (started) stream(1, 1'b0, 2'd0);

        // Stalls with a fixed ready pattern.
        for (int i = 0; i < 4; i++) do_write(2'(i), 32'h2222_0000 + i);
        start_and_check(1'b0, 2'd0, 32'h0, started);
        if (started) stream(2, 1'b0, 2'd0);

        // Slot 3 written in the same cycle as start.
        for (int i = 0; i < 3; i++) do_write(2'(i), 32'h3333_0000 + i);
        start_and_check(1'b1, 2'd3, 32'h0000_0055, started);
        check("same_cycle_started", {31'b0, started}, 32'd1);
        if (started) stream(0, 1'b0, 2'd0);

        // Writes while streaming are dropped (slot 0 and a not-yet-streamed slot).
        for (int i = 0; i < 4; i++) do_write(2'(i), 32'h4444_0000 + i);
        start_and_check(1'b0, 2'd0, 32'h0, started);
        if (started) stream(0, 1'b1, 2'd0);
        for (int i = 0; i < 4; i++) do_write(2'(i), 32'h4545_0000 + i);
        start_and_check(1'b0, 2'd0, 32'h0, started);
        if (started) stream(1, 1'b1, 2'd3);

        // Replay (or rejection) of a start without reload.
        start_and_check(1'b0, 2'd0, 32'h0, started);
`ifdef WEIGHT_BANK_REPLAY_EN
        check("replay_started", {31'b0, started}, 32'd1);
`else
        check("no_reload_rejected", {31'b0, started}, 32'd0);
`endif
        if (started) stream(1, 1'b0, 2'd0);

        // Reset mid-stream while word 2 is presented.
        for (int i = 0; i < 4; i++) do_write(2'(i), 32'h5555_0000 + i);
        start_and_check(1'b0, 2'd0, 32'h0, started);
        word_ready = 1'b1;
        tick();
        tick();
        check("pre_reset_index", {30'b0, word_index}, 32'd2);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        word_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("after_reset_no_done", {31'b0, done}, 32'd0);
        start_and_check(1'b0, 2'd0, 32'h0, started);
        check("after_reset_rejected", {31'b0, started}, 32'd0);

        // Randomized loads, starts and backpressure.
        for (int it = 0; it < 25; it++) begin
            int nwr;
            nwr = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4);
            if (nwr == 0) begin
                for (int i = 0; i < 4; i++) do_write(2'(i), $urandom);
            end else begin
                for (int i = 0; i < nwr; i++) do_write(2'($urandom_range(0, 3)), $urandom);
            end
            start_and_check(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, started);
            if (started) stream(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
